// File: rtl/reg_wb_arbiter.sv
// Write-port controller for the single-write-port register file: zero-fill
// sweep after reset or soft_clear, then round-robin arbitration of two writers.
module reg_wb_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     soft_clear,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [ADDRESS_WIDTH-1:0] a_rd,
  input  logic [DATA_WIDTH-1:0]    a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [ADDRESS_WIDTH-1:0] b_rd,
  input  logic [DATA_WIDTH-1:0]    b_data,
  output logic                     rf_we,
  output logic [ADDRESS_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  output logic                     init_done
);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_cnt;
  logic                     r_lastA;

  logic w_run;
  logic w_grantA;
  logic w_grantB;

  // soft_clear blocks every grant in the cycle it is seen; a tie goes to the
  // requester that did not win last time.
  assign w_run    = (r_state == ST_RUN) && !soft_clear;
  assign w_grantA = w_run && a_valid && (!b_valid || !r_lastA);
  assign w_grantB = w_run && b_valid && (!a_valid || r_lastA);

  assign a_ready = w_grantA;
  assign b_ready = w_grantB;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_cnt     <= '0;
      r_lastA   <= 1'b0;
      rf_we     <= 1'b0;
      rf_addr   <= '0;
      rf_wdata  <= '0;
      init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          rf_we    <= 1'b1;
          rf_addr  <= r_cnt;
          rf_wdata <= '0;
          if (r_cnt == '1) begin
            r_state   <= ST_RUN;
            init_done <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (soft_clear) begin
            r_state   <= ST_CLEAR;
            r_cnt     <= '0;
            init_done <= 1'b0;
            rf_we     <= 1'b0;
          end else if (w_grantA) begin
            // x0 writes are consumed but never reach the array
            rf_we    <= (a_rd != '0);
            rf_addr  <= a_rd;
            rf_wdata <= a_data;
            r_lastA  <= 1'b1;
          end else if (w_grantB) begin
            rf_we    <= (b_rd != '0);
            rf_addr  <= b_rd;
            rf_wdata <= b_data;
            r_lastA  <= 1'b0;
          end else begin
            rf_we <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
